inst_trace_buffer: RTL and testbench
====================================

Name: inst_trace_buffer

Overview:
- Debug capture stage directly downstream of single_period_cpu.
- Consumes the CPU's per-cycle pc/inst outputs.
- When armed, it waits for a trigger PC, then records a window of (pc, inst) pairs into an on-chip FIFO.
- A host or bench drains the FIFO over a valid/ready port, independently of capture.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the capture-length input and the drop counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  input  `ADDR_LEN  CPU program counter of the instruction executing this cycle.
- inst  input  `INSTR_LEN  CPU instruction word for that pc.
- arm  input  1  one-cycle pulse; starts waiting for the trigger.
- disarm  input  1  one-cycle pulse; abort to IDLE.
- clear  input  1  one-cycle pulse; flush FIFO and drop counter.
- trig_pc  input  `ADDR_LEN  trigger address; sampled when arm is accepted.
- cap_len  input  CNT_W  cycles to capture; sampled when arm is accepted. 0 means unbounded.
- rd_valid  output  1  FIFO head is valid.
- rd_ready  input  1  consumer accepts the head.
- rd_pc  output  `ADDR_LEN  pc at the FIFO head.
- rd_inst  output  `INSTR_LEN  inst at the FIFO head.
- state_o  output  2  current state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  output  CNT_W  number of capture cycles lost to a full FIFO; saturates at all-ones.

Behaviour:
- Reset, rst asynchronous: state IDLE, FIFO empty, level 0, drop_cnt 0, rd_valid 0, rd_pc 0, rd_inst 0. Latched trig_pc and cap_len are cleared to 0.
- rd_pc and rd_inst read 0 whenever rd_valid=0.
- FIFO is show-ahead:
  - rd_valid = (level != 0).
  - A pop occurs on a rising edge where rd_valid & rd_ready.
  - Head data changes on the edge after a pop.
- Push: the pc/inst present during cycle N are written at the rising edge ending cycle N. If the FIFO was empty, they appear on rd_* in cycle N+1 (1-cycle latency).
- Full handling: a push is accepted if level < DEPTH, or if a pop happens on the same edge. Otherwise the entry is discarded and drop_cnt increments (saturating).
- Simultaneous push and pop: level is unchanged. Pointers wrap modulo DEPTH.
- State machine; control priority per edge is clear > disarm > arm:
  - IDLE, arm: latch trig_pc and cap_len, go to ARMED.
  - ARMED, pc == latched trig_pc: capture this cycle's pair, go to CAPTURE, remaining = cap_len - 1.
    - If cap_len == 1, go straight to DONE instead.
  - CAPTURE: capture every cycle and decrement remaining per cycle, whether the entry was stored or dropped.
    - When remaining reaches 0, that edge's capture is the last one and the state goes to DONE.
    - cap_len == 0 never terminates.
  - DONE, arm: re-latch trig_pc and cap_len, go to ARMED. The FIFO is not flushed.
  - arm in ARMED or CAPTURE is ignored.
  - disarm from any state goes to IDLE. FIFO contents are kept. Any capture on that edge is suppressed.
- clear: empties the FIFO and zeroes drop_cnt on that edge. No push or pop happens on that edge. State is unaffected.
- Draining is allowed in every state, including during capture.
- Reset asserted mid-capture aborts immediately to reset values.

Decomposition:
- Add state encodings (`TRC_IDLE, `TRC_ARMED, `TRC_CAPTURE, `TRC_DONE) and the trace width `TRC_W = `ADDR_LEN + `INSTR_LEN to defines.v.
- One sub-module, trace_fifo: DEPTH x `TRC_W show-ahead FIFO with push, pop, clear, full, empty and level, same clk/rst.
- The top level holds the FSM, trigger compare, remaining counter and drop counter.

Test Plan:
1. Reset check: assert rst mid-cycle during CAPTURE → state_o=0, level=0, rd_valid=0, drop_cnt=0 asynchronously.
2. Basic window: trig_pc=0x8, cap_len=3, arm. The pc sequence runs 0,4,8,C,10,14.
   - Required: FIFO holds pc 8, C, 10 with their insts.
   - state_o=3 after the pc=0x10 edge; pc=0x14 is not captured.
3. Overflow: DEPTH=16, cap_len=20, rd_ready=0 → level=16, drop_cnt=4, DONE. Then drain 16 entries in order; the last entry has pc = trigger + 0x3C.
4. Full with concurrent pop: FIFO full, rd_ready=1 during CAPTURE → level stays 16, drop_cnt unchanged, data order preserved.
5. Control collisions:
   - clear+disarm on the same edge in CAPTURE → IDLE, level=0.
   - arm while ARMED → trig_pc latch unchanged.
6. Unbounded capture: cap_len=0 runs 40 cycles while draining every cycle → 40 entries received, no drops, stays in CAPTURE until disarm.

Source files
------------

// File: rtl/inst_trace_buffer_pkg.sv
// Shared widths, trace entry layout and capture FSM encoding for the instruction trace buffer.
// Imported by the interface, the trace FIFO and the top level.
package inst_trace_buffer_pkg;

  localparam int ADDR_LEN  = 32;
  localparam int INSTR_LEN = 32;
  localparam int TRC_W     = ADDR_LEN + INSTR_LEN;

  typedef enum logic [1:0] {
    TRC_IDLE    = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_CAPTURE = 2'd2,
    TRC_DONE    = 2'd3
  } trc_state_e;

  typedef struct packed {
    logic [ADDR_LEN-1:0]  pc;
    logic [INSTR_LEN-1:0] inst;
  } trc_entry_t;

endpackage

// File: rtl/inst_trace_buffer_if.sv
// CPU-side trace tap plus the valid/ready drain port of the trace buffer.
// Master is the CPU/host side; slave is the trace buffer.
interface inst_trace_buffer_if;
  import inst_trace_buffer_pkg::*;

  logic [ADDR_LEN-1:0]  pc;
  logic [INSTR_LEN-1:0] inst;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ADDR_LEN-1:0]  rd_pc;
  logic [INSTR_LEN-1:0] rd_inst;

  modport master (output pc, inst, rd_ready, input rd_valid, rd_pc, rd_inst);
  modport slave  (input pc, inst, rd_ready, output rd_valid, rd_pc, rd_inst);

endinterface

// File: rtl/inst_trace_buffer_trace_fifo.sv
// Show-ahead DEPTH x TRC_W FIFO; push visible at head one cycle later, head reads 0 when empty.
// Push while full is refused unless a pop shares the edge; clr wins over push and pop.
module inst_trace_buffer_trace_fifo
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  trc_entry_t    wr_dat,
  output trc_entry_t    rd_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  trc_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & ~clr & (~full | do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/inst_trace_buffer.sv
// Arm/trigger/capture FSM feeding a show-ahead trace FIFO; captured pairs reach rd_* one cycle after capture.
// Drain is independent of capture; pairs that meet a full FIFO without a same-edge pop are counted in drop_cnt.
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  inst_trace_buffer_if.slave        trc,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      clear,
  input  logic [ADDR_LEN-1:0]       trig_pc,
  input  logic [CNT_W-1:0]          cap_len,
  output logic [1:0]                state_o,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          drop_cnt
);

  trc_state_e          state;
  trc_state_e          state_nxt;
  logic [ADDR_LEN-1:0] trig_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    rem;
  logic                unbounded;
  logic                trig_hit;
  logic                cap_fire;
  logic                latch_en;
  logic                push_req;
  logic                pop_eff;
  logic                fifo_full;
  logic                fifo_empty;
  trc_entry_t          wr_dat;
  trc_entry_t          rd_dat;

  assign unbounded = (len_q == '0);
  assign trig_hit  = (state == TRC_ARMED) && (trc.pc == trig_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TRC_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (disarm) begin
      state_nxt = TRC_IDLE;
    end else begin
      case (state)
        TRC_IDLE:    if (arm) state_nxt = TRC_ARMED;
        TRC_ARMED:   if (trig_hit) state_nxt = (len_q == CNT_W'(1)) ? TRC_DONE : TRC_CAPTURE;
        TRC_CAPTURE: if (!unbounded && rem == CNT_W'(1)) state_nxt = TRC_DONE;
        TRC_DONE:    if (arm) state_nxt = TRC_ARMED;
        default:     state_nxt = TRC_IDLE;
      endcase
    end
  end

  always_comb begin
    cap_fire = trig_hit || (state == TRC_CAPTURE);
    latch_en = arm && !disarm && ((state == TRC_IDLE) || (state == TRC_DONE));
    // A clear edge still consumes a capture slot, it just stores nothing.
    push_req = cap_fire && !disarm && !clear;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
      len_q  <= '0;
      rem    <= '0;
    end else begin
      if (latch_en) begin
        trig_q <= trig_pc;
        len_q  <= cap_len;
      end
      if (!disarm) begin
        if (trig_hit)                  rem <= len_q - CNT_W'(1);
        else if (state == TRC_CAPTURE) rem <= rem - CNT_W'(1);
      end
    end
  end

  assign pop_eff = trc.rd_valid & trc.rd_ready & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (push_req && fifo_full && !pop_eff && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign wr_dat.pc   = trc.pc;
  assign wr_dat.inst = trc.inst;

  inst_trace_buffer_trace_fifo #(.DEPTH(DEPTH)) u_trace_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_req),
    .pop    (pop_eff),
    .clr    (clear),
    .wr_dat (wr_dat),
    .rd_dat (rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign trc.rd_valid = ~fifo_empty;
  assign trc.rd_pc    = rd_dat.pc;
  assign trc.rd_inst  = rd_dat.inst;
  assign state_o      = state;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Scoreboard bench for inst_trace_buffer: expected pairs are queued as capture cycles are driven
// and checked in order as the drain port pops them.
module tb_inst_trace_buffer;
  import inst_trace_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              disarm;
  logic              clear;
  logic [31:0]       trig_pc;
  logic [CNT_W-1:0]  cap_len;
  logic [1:0]        state_o;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [31:0] last_pc;
  logic [63:0] sb[$];

  inst_trace_buffer_if bus();

  inst_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .trc      (bus),
    .arm      (arm),
    .disarm   (disarm),
    .clear    (clear),
    .trig_pc  (trig_pc),
    .cap_len  (cap_len),
    .state_o  (state_o),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return {p[15:0], ~p[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_pc(input logic [31:0] p, input bit expect_cap);
    bus.pc   = p;
    bus.inst = inst_of(p);
    if (expect_cap) sb.push_back({p, inst_of(p)});
  endtask

  // Compare the head on every pop this cycle, then advance one clock and drop the pulses.
  task automatic tick();
    logic [63:0] e;
    if (bus.rd_valid && bus.rd_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, expected no entry", bus.rd_pc, bus.rd_inst);
      end else begin
        e = sb.pop_front();
        if ({bus.rd_pc, bus.rd_inst} !== e) begin
          miscompares++;
          $display("FAIL pop_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                   bus.rd_pc, bus.rd_inst, e[63:32], e[31:0]);
        end
        pops++;
        last_pc = bus.rd_pc;
      end
    end
    @(posedge clk);
    #1;
    arm    = 1'b0;
    disarm = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    drive_pc(32'hFFF0, 1'b0);
    bus.rd_ready = 1'b1;
    while ((bus.rd_valid || sb.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.rd_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: rd_valid=%b pending=%0d, expected empty", name, bus.rd_valid, sb.size());
    end
    vectors++;
    if (bus.rd_pc !== 32'h0 || bus.rd_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL %s_idle_data: rd_pc=%h rd_inst=%h, expected 0", name, bus.rd_pc, bus.rd_inst);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (state_o !== 2'd0 || level !== 5'd0 || bus.rd_valid !== 1'b0 || drop_cnt !== '0 ||
        bus.rd_pc !== 32'h0 || bus.rd_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d level=%0d rd_valid=%b drop=%0d rd_pc=%h, expected all 0",
               state_o, level, bus.rd_valid, drop_cnt, bus.rd_pc);
    end
  endtask

  task automatic test_basic_window();
    logic [31:0] seq [6];
    seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    trig_pc = 32'h8; cap_len = 16'd3; bus.rd_ready = 1'b0;
    drive_pc(32'h100, 1'b0); arm = 1'b1; tick();
    vectors++;
    if (state_o !== 2'd1) begin
      miscompares++; $display("FAIL basic_armed: state=%0d, expected 1", state_o);
    end
    foreach (seq[i]) begin
      drive_pc(seq[i], seq[i] >= 32'h8 && seq[i] <= 32'h10);
      tick();
      if (seq[i] == 32'h10) begin
        vectors++;
        if (state_o !== 2'd3) begin
          miscompares++; $display("FAIL basic_done: state=%0d, expected 3", state_o);
        end
      end
    end
    vectors++;
    if (level !== 5'd3) begin
      miscompares++; $display("FAIL basic_level: level=%0d, expected 3", level);
    end
    drain("basic");
  endtask

  task automatic test_overflow();
    logic [31:0] base = 32'h1000;
    trig_pc = base; cap_len = 16'd20; bus.rd_ready = 1'b0;
    drive_pc(32'hF000, 1'b0); arm = 1'b1; tick();
    for (int i = 0; i < 24; i++) begin
      drive_pc(base + 32'(4 * i), i < 16);
      tick();
    end
    vectors++;
    if (level !== 5'd16 || drop_cnt !== 16'd4 || state_o !== 2'd3) begin
      miscompares++;
      $display("FAIL overflow_status: level=%0d drop=%0d state=%0d, expected 16 4 3", level, drop_cnt, state_o);
    end
    pops = 0;
    drain("overflow");
    vectors++;
    if (pops != 16 || last_pc !== base + 32'h3C) begin
      miscompares++;
      $display("FAIL overflow_last: pops=%0d last_pc=%h, expected 16 %h", pops, last_pc, base + 32'h3C);
    end
    clear = 1'b1; tick();
    vectors++;
    if (drop_cnt !== '0 || level !== 5'd0) begin
      miscompares++; $display("FAIL clear_drop: drop=%0d level=%0d, expected 0 0", drop_cnt, level);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] base = 32'h2000;
    trig_pc = base; cap_len = 16'd0; bus.rd_ready = 1'b0;
    drive_pc(32'hF000, 1'b0); arm = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      drive_pc(base + 32'(4 * i), 1'b1);
      tick();
    end
    vectors++;
    if (level !== 5'd16 || state_o !== 2'd2) begin
      miscompares++; $display("FAIL fullpop_fill: level=%0d state=%0d, expected 16 2", level, state_o);
    end
    bus.rd_ready = 1'b1;
    for (int i = 16; i < 26; i++) begin
      drive_pc(base + 32'(4 * i), 1'b1);
      tick();
      vectors++;
      if (level !== 5'd16) begin
        miscompares++; $display("FAIL fullpop_level: level=%0d, expected 16", level);
      end
    end
    vectors++;
    if (drop_cnt !== '0) begin
      miscompares++; $display("FAIL fullpop_drop: drop=%0d, expected 0", drop_cnt);
    end
    disarm = 1'b1; drive_pc(base + 32'(4 * 26), 1'b0); tick();
    vectors++;
    if (state_o !== 2'd0) begin
      miscompares++; $display("FAIL fullpop_disarm: state=%0d, expected 0", state_o);
    end
    drain("fullpop");
  endtask

  task automatic test_collisions();
    logic [31:0] base = 32'h3000;
    trig_pc = base; cap_len = 16'd0; bus.rd_ready = 1'b0;
    drive_pc(32'hF000, 1'b0); arm = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      drive_pc(base + 32'(4 * i), 1'b0);
      tick();
    end
    clear = 1'b1; disarm = 1'b1; drive_pc(base + 32'hC, 1'b0); tick();
    vectors++;
    if (state_o !== 2'd0 || level !== 5'd0 || bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_disarm: state=%0d level=%0d rd_valid=%b, expected 0 0 0", state_o, level, bus.rd_valid);
    end
    trig_pc = 32'h4000; cap_len = 16'd2; arm = 1'b1; drive_pc(32'hF000, 1'b0); tick();
    trig_pc = 32'h5000; cap_len = 16'd5; arm = 1'b1; drive_pc(32'hF004, 1'b0); tick();
    drive_pc(32'h5000, 1'b0); tick();
    vectors++;
    if (state_o !== 2'd1 || level !== 5'd0) begin
      miscompares++; $display("FAIL rearm_ignored: state=%0d level=%0d, expected 1 0", state_o, level);
    end
    drive_pc(32'h4000, 1'b1); tick();
    drive_pc(32'h4004, 1'b1); tick();
    vectors++;
    if (state_o !== 2'd3 || level !== 5'd2) begin
      miscompares++; $display("FAIL rearm_window: state=%0d level=%0d, expected 3 2", state_o, level);
    end
    drain("collide");
  endtask

  task automatic test_unbounded();
    logic [31:0] base = 32'h6000;
    trig_pc = base; cap_len = 16'd0; bus.rd_ready = 1'b1; pops = 0;
    drive_pc(32'hF000, 1'b0); arm = 1'b1; tick();
    for (int i = 0; i < 40; i++) begin
      drive_pc(base + 32'(4 * i), 1'b1);
      tick();
    end
    vectors++;
    if (state_o !== 2'd2 || drop_cnt !== '0) begin
      miscompares++; $display("FAIL unbounded_run: state=%0d drop=%0d, expected 2 0", state_o, drop_cnt);
    end
    disarm = 1'b1; drive_pc(32'hF000, 1'b0); tick();
    vectors++;
    if (state_o !== 2'd0) begin
      miscompares++; $display("FAIL unbounded_disarm: state=%0d, expected 0", state_o);
    end
    drain("unbounded");
    vectors++;
    if (pops != 40) begin
      miscompares++; $display("FAIL unbounded_count: received=%0d, expected 40", pops);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] base = 32'h7000;
    trig_pc = base; cap_len = 16'd0; bus.rd_ready = 1'b0;
    drive_pc(32'hF000, 1'b0); arm = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      drive_pc(base + 32'(4 * i), 1'b0);
      tick();
    end
    vectors++;
    if (state_o !== 2'd2 || level !== 5'd5) begin
      miscompares++; $display("FAIL mid_precheck: state=%0d level=%0d, expected 2 5", state_o, level);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (state_o !== 2'd0 || level !== 5'd0 || bus.rd_valid !== 1'b0 || drop_cnt !== '0 || bus.rd_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: state=%0d level=%0d rd_valid=%b drop=%0d rd_pc=%h, expected all 0",
               state_o, level, bus.rd_valid, drop_cnt, bus.rd_pc);
    end
    #2 rst = 1'b0;
    drive_pc(base, 1'b0); tick();
    vectors++;
    if (state_o !== 2'd0 || level !== 5'd0) begin
      miscompares++; $display("FAIL post_reset: state=%0d level=%0d, expected 0 0", state_o, level);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; disarm = 1'b0; clear = 1'b0;
    trig_pc = '0; cap_len = '0; bus.rd_ready = 1'b0;
    drive_pc(32'hF000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic_window();
    test_overflow();
    test_full_pop();
    test_collisions();
    test_unbounded();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
